cov_accum_sym: RTL and testbench

Parametrised streaming covariance accumulator for the whitening stage. It takes the upper-triangle channel-pair products of each valid sample and sums them over a block of 2^LOG2_SAMPLES valid samples. At the end of each block it scales and saturates the sums and publishes a full symmetric N_CH×N_CH covariance matrix with a one-cycle valid strobe. It sits between the pairwise product multipliers and the eigen-decomposition / whitening-matrix logic.

---
 rtl/cov_accum_sym_if.sv | 29 ++
 rtl/cov_accum_sym.sv | 147 ++++++++++++++
 tb/tb_cov_accum_sym.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cov_accum_sym_if.sv
// Bus bundle for cov_accum_sym: product stream in, covariance matrix out.
interface cov_accum_sym_if #(
    parameter int N_CH         = 4,
    parameter int PROD_W       = 52,
    parameter int OUT_W        = 16,
    parameter int LOG2_SAMPLES = 7
);
    localparam int NTRI = N_CH * (N_CH + 1) / 2;

    logic                          En;
    logic                          one_shot;
    logic                          in_valid;
    logic [NTRI*PROD_W-1:0]        prod_in;
    logic [N_CH*N_CH*OUT_W-1:0]    cov_out;
    logic                          out_valid;
    logic                          sat_flag;
    logic [LOG2_SAMPLES-1:0]       sample_cnt;
    logic                          busy;

    modport master (
        output En, one_shot, in_valid, prod_in,
        input  cov_out, out_valid, sat_flag, sample_cnt, busy
    );

    modport slave (
        input  En, one_shot, in_valid, prod_in,
        output cov_out, out_valid, sat_flag, sample_cnt, busy
    );
endinterface

// File: rtl/cov_accum_sym.sv
// Streaming covariance accumulator: sums upper-triangle channel-pair products
// over 2^LOG2_SAMPLES valid samples, then scales, saturates and publishes a
// symmetric N_CH x N_CH matrix with a one-cycle valid strobe.
module cov_accum_sym #(
    parameter int N_CH         = 4,
    parameter int PROD_W       = 52,
    parameter int OUT_W        = 16,
    parameter int LOG2_SAMPLES = 7,
    parameter int FRAC_SHIFT   = 18
) (
    input  logic            clk,
    input  logic            rst_n,
    cov_accum_sym_if.slave  bus
);
    localparam int NTRI  = N_CH * (N_CH + 1) / 2;
    localparam int ACC_W = PROD_W + LOG2_SAMPLES;
    localparam int SH    = LOG2_SAMPLES + FRAC_SHIFT;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q [NTRI];
    logic signed [ACC_W-1:0]  acc_d [NTRI];
    logic [LOG2_SAMPLES-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]         tri_q [NTRI];
    logic [OUT_W-1:0]         tri_d [NTRI];
    logic                     sat_q, sat_d;
    logic                     ov_q, ov_d;

    logic signed [PROD_W-1:0] prod_s  [NTRI];
    logic signed [ACC_W-1:0]  sum     [NTRI];
    logic signed [ACC_W-1:0]  shr     [NTRI];
    logic [OUT_W-1:0]         sat_val [NTRI];
    logic [NTRI-1:0]          clamp;

    logic accept;
    logic take;
    logic final_s;

    // IDLE accepts too, so a sample presented on the En rising cycle counts.
    assign accept  = bus.En && (state_q != HOLD);
    assign take    = accept && bus.in_valid;
    assign final_s = take && (cnt_q == '1);

    // Next-state logic; En low overrides everything.
    always_comb begin
        state_d = state_q;
        if (!bus.En) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = (final_s && bus.one_shot) ? HOLD : ACC;
                ACC:     if (final_s && bus.one_shot) state_d = HOLD;
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    // Per-element running sum, floor scaling and saturation.
    always_comb begin
        clamp = '0;
        for (int unsigned k = 0; k < NTRI; k++) begin
            prod_s[k]  = bus.prod_in[k*PROD_W +: PROD_W];
            sum[k]     = acc_q[k] + ACC_W'(prod_s[k]);
            shr[k]     = sum[k] >>> SH;
            sat_val[k] = shr[k][OUT_W-1:0];
            if (shr[k] > SAT_MAX) begin
                sat_val[k] = SAT_MAX[OUT_W-1:0];
                clamp[k]   = 1'b1;
            end else if (shr[k] < SAT_MIN) begin
                sat_val[k] = SAT_MIN[OUT_W-1:0];
                clamp[k]   = 1'b1;
            end
        end
    end

    // Accumulator, counter and published-result next state.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        tri_d = tri_q;
        sat_d = sat_q;
        ov_d  = 1'b0;
        if (!bus.En) begin
            for (int unsigned k = 0; k < NTRI; k++) acc_d[k] = '0;
            cnt_d = '0;
        end else if (final_s) begin
            for (int unsigned k = 0; k < NTRI; k++) begin
                acc_d[k] = '0;
                tri_d[k] = sat_val[k];
            end
            cnt_d = '0;
            sat_d = |clamp;
            ov_d  = 1'b1;
        end else if (take) begin
            acc_d = sum;
            cnt_d = cnt_q + LOG2_SAMPLES'(1);
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < NTRI; k++) begin
                acc_q[k] <= '0;
                tri_q[k] <= '0;
            end
            cnt_q <= '0;
            sat_q <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tri_q   <= tri_d;
            sat_q   <= sat_d;
            ov_q    <= ov_d;
        end
    end

    // Lower triangle is a wired mirror of the stored upper triangle.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_row
        for (genvar gj = 0; gj < N_CH; gj++) begin : g_col
            localparam int R = (gi < gj) ? gi : gj;
            localparam int C = (gi < gj) ? gj : gi;
            localparam int K = R * N_CH - (R * (R - 1)) / 2 + (C - R);
            assign bus.cov_out[(gi*N_CH+gj)*OUT_W +: OUT_W] = tri_q[K];
        end
    end

    assign bus.out_valid  = ov_q;
    assign bus.sat_flag   = sat_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.busy       = (state_q == ACC);

endmodule

// File: tb/tb_cov_accum_sym.sv
// Scoreboard bench for cov_accum_sym: stimulus pushes expected matrices with
// their expected strobe cycle; a negedge monitor pops and compares.
module tb_cov_accum_sym;
    localparam int N    = 4;
    localparam int PW   = 52;
    localparam int OW   = 16;
    localparam int L2   = 7;
    localparam int FS   = 18;
    localparam int SH   = L2 + FS;
    localparam int NS   = 1 << L2;
    localparam int NTRI = N * (N + 1) / 2;

    typedef struct packed {
        logic [31:0]         cyc;
        logic                sat;
        logic [NTRI*OW-1:0]  v;
    } exp_t;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int unsigned drv_cyc;
    int errors;
    int checks;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [NTRI*OW-1:0] last_v;
    logic [PW-1:0] cur_p [NTRI];
    int tidx [N][N];

    cov_accum_sym_if #(.N_CH(N), .PROD_W(PW), .OUT_W(OW), .LOG2_SAMPLES(L2)) bus_if ();

    cov_accum_sym #(
        .N_CH(N), .PROD_W(PW), .OUT_W(OW), .LOG2_SAMPLES(L2), .FRAC_SHIFT(FS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_mat(input string name, input logic [NTRI*OW-1:0] v);
        logic signed [OW-1:0] a;
        logic signed [OW-1:0] e;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a = bus_if.cov_out[(i*N+j)*OW +: OW];
                e = v[tidx[i][j]*OW +: OW];
                chk($sformatf("%s(%0d,%0d)", name, i, j), a, e);
            end
        end
    endtask

    // Apply current inputs for one clock; leaves time at posedge+1.
    task automatic drive(input logic v);
        bus_if.in_valid = v;
        for (int k = 0; k < NTRI; k++) bus_if.prod_in[k*PW +: PW] = cur_p[k];
        drv_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input longint val);
        for (int k = 0; k < NTRI; k++) cur_p[k] = PW'(val);
    endtask

    task automatic block(input int n);
        for (int s = 0; s < n; s++) drive(1'b1);
        bus_if.in_valid = 1'b0;
    endtask

    function automatic logic [NTRI*OW-1:0] uniform(input logic [OW-1:0] val);
        logic [NTRI*OW-1:0] r;
        for (int k = 0; k < NTRI; k++) r[k*OW +: OW] = val;
        return r;
    endfunction

    task automatic push_exp(input int unsigned c, input logic [NTRI*OW-1:0] v, input logic s);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.sat = s;
        exp_q.push_back(e);
        last_v = v;
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus_if.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got strobe at cycle %0d expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_cycle", cyc, mon_e.cyc);
                check_mat("cov", mon_e.v);
                chk("sat_flag", bus_if.sat_flag, mon_e.sat);
            end
        end
    end

    longint rp   [NTRI];
    longint msum [NTRI];
    int     mcnt;
    logic [NTRI*OW-1:0] mv;
    logic   msat;
    longint t;
    logic   v;
    bit     got_rand;

    initial begin
        int kk;
        kk = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = r; c < N; c++) begin
                tidx[r][c] = kk;
                tidx[c][r] = kk;
                kk++;
            end
        end
        errors = 0;
        checks = 0;
        last_v = '0;
        rst_n = 1'b0;
        bus_if.En = 1'b0;
        bus_if.one_shot = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.prod_in = '0;
        set_all(0);
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check_mat("rst_cov", '0);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_sat", bus_if.sat_flag, 0);
        chk("rst_cnt", bus_if.sample_cnt, 0);
        chk("rst_busy", bus_if.busy, 0);
        rst_n = 1'b1;
        drive(1'b0);

        // Back-to-back continuous blocks with directed products
        bus_if.En = 1'b1;
        set_all(longint'(100) <<< 18);
        block(NS);
        push_exp(drv_cyc + 1, uniform(16'd100), 1'b0);
        chk("cnt_wrap", bus_if.sample_cnt, 0);
        chk("busy_acc", bus_if.busy, 1);

        set_all(-1);
        block(NS);
        push_exp(drv_cyc + 1, uniform(16'hFFFF), 1'b0);

        set_all(0);
        cur_p[1] = PW'(longint'(3) <<< 25);
        block(NS);
        mv = '0;
        mv[1*OW +: OW] = 16'd384;
        push_exp(drv_cyc + 1, mv, 1'b0);

        set_all(longint'(1) <<< 40);
        block(NS);
        push_exp(drv_cyc + 1, uniform(16'h7FFF), 1'b1);

        set_all(-(longint'(1) <<< 40));
        block(NS);
        push_exp(drv_cyc + 1, uniform(16'h8000), 1'b1);

        set_all(longint'(100) <<< 18);
        block(NS);
        push_exp(drv_cyc + 1, uniform(16'd100), 1'b0);

        // Random gaps, random products, reference sums
        for (int k = 0; k < NTRI; k++) msum[k] = 0;
        mcnt = 0;
        got_rand = 1'b0;
        for (int c = 0; c < 300 || (!got_rand && c < 800); c++) begin
            v = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < NTRI; k++) begin
                rp[k] = longint'($signed($urandom)) <<< (2 * k);
                cur_p[k] = PW'(rp[k]);
            end
            drive(v);
            if (v) begin
                for (int k = 0; k < NTRI; k++) msum[k] += rp[k];
                mcnt++;
                if (mcnt == NS) begin
                    msat = 1'b0;
                    for (int k = 0; k < NTRI; k++) begin
                        t = msum[k] >>> SH;
                        if (t > 32767) begin
                            t = 32767;
                            msat = 1'b1;
                        end else if (t < -32768) begin
                            t = -32768;
                            msat = 1'b1;
                        end
                        mv[k*OW +: OW] = OW'(t);
                        msum[k] = 0;
                    end
                    mcnt = 0;
                    push_exp(drv_cyc + 1, mv, msat);
                    got_rand = 1'b1;
                end
            end
        end
        chk("rand_block_seen", got_rand, 1);
        bus_if.En = 1'b0;
        drive(1'b0);
        drive(1'b0);
        chk("en_low_busy", bus_if.busy, 0);
        chk("en_low_cnt", bus_if.sample_cnt, 0);
        check_mat("en_low_hold", last_v);

        // Partial block abandoned by En drop
        bus_if.En = 1'b1;
        set_all(longint'(1) <<< 30);
        block(50);
        chk("partial_cnt", bus_if.sample_cnt, 50);
        bus_if.En = 1'b0;
        drive(1'b0);
        drive(1'b0);
        chk("abort_cnt", bus_if.sample_cnt, 0);
        check_mat("abort_hold", last_v);
        bus_if.En = 1'b1;
        set_all(longint'(5) <<< 25);
        block(NS);
        push_exp(drv_cyc + 1, uniform(16'd640), 1'b0);

        // En drop coinciding with the final sample: block discarded
        set_all(longint'(9) <<< 25);
        block(NS - 1);
        bus_if.En = 1'b0;
        drive(1'b1);
        bus_if.in_valid = 1'b0;
        drive(1'b0);
        drive(1'b0);
        chk("en_final_cnt", bus_if.sample_cnt, 0);
        chk("en_final_busy", bus_if.busy, 0);
        check_mat("en_final_hold", last_v);

        // One-shot: stop after one block until En toggles
        bus_if.En = 1'b1;
        bus_if.one_shot = 1'b1;
        set_all(longint'(2) <<< 25);
        block(NS);
        push_exp(drv_cyc + 1, uniform(16'd256), 1'b0);
        chk("oneshot_busy", bus_if.busy, 0);
        set_all(longint'(1) <<< 35);
        block(20);
        chk("hold_cnt", bus_if.sample_cnt, 0);
        chk("hold_busy", bus_if.busy, 0);
        check_mat("hold_cov", last_v);
        bus_if.En = 1'b0;
        drive(1'b0);
        bus_if.En = 1'b1;
        set_all(longint'(3) <<< 25);
        block(NS);
        push_exp(drv_cyc + 1, uniform(16'd384), 1'b0);
        chk("oneshot2_busy", bus_if.busy, 0);

        // Asynchronous reset mid-block
        bus_if.one_shot = 1'b0;
        bus_if.En = 1'b0;
        drive(1'b0);
        bus_if.En = 1'b1;
        set_all(longint'(4) <<< 25);
        for (int s = 0; s < 77; s++) drive(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_mat("arst_cov", '0);
        chk("arst_out_valid", bus_if.out_valid, 0);
        chk("arst_sat", bus_if.sat_flag, 0);
        chk("arst_cnt", bus_if.sample_cnt, 0);
        chk("arst_busy", bus_if.busy, 0);
        bus_if.in_valid = 1'b0;
        bus_if.En = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) drive(1'b0);

        chk("pending_strobes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
